riscv_encoder: RTL and testbench

RISCV_ENCODER -- requirements
Module: riscv_encoder

---
 rtl/riscv_encoder.sv | 194 +++++++++++++++++++
 tb/tb_riscv_encoder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_encoder.sv
// riscv_encoder: two-stage RV32 instruction encoder.
// Stage 1 registers the accepted field set. Stage 2 registers the packed
// 32-bit word and an error flag.
// The word is zeroed and err raised when the format is illegal, the opcode
// does not belong to the format, or a branch/jump offset is odd.
module riscv_encoder (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [2:0]  format_i,
    input  logic [6:0]  op_i,
    input  logic [2:0]  funct_3_i,
    input  logic [6:0]  funct_7_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    input  logic        flush_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] instr_o,
    output logic        err_o,
    output logic [15:0] cnt_ok_o,
    output logic [15:0] cnt_err_o
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Packs the fields for one format. Returns {err, word}; word is 0 on err.
    function automatic logic [32:0] encode(
        input logic [2:0]  fmt,
        input logic [6:0]  op,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        logic [31:0] word;
        logic        bad;
        word = 32'h0;
        bad  = 1'b0;
        case (fmt)
            FMT_R: begin
                word = {f7, rs2, rs1, f3, rd, op};
                bad  = (op != OP_OP);
            end
            FMT_I: begin
                word = {imm[11:0], rs1, f3, rd, op};
                bad  = !((op == OP_OPIMM) || (op == OP_LOAD) || (op == OP_JALR));
            end
            FMT_S: begin
                word = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
                bad  = (op != OP_STORE);
            end
            FMT_B: begin
                word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
                bad  = (op != OP_BRANCH) || imm[0];
            end
            FMT_U: begin
                word = {imm[31:12], rd, op};
                bad  = !((op == OP_LUI) || (op == OP_AUIPC));
            end
            FMT_J: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                bad  = (op != OP_JAL) || imm[0];
            end
            default: begin
                word = 32'h0;
                bad  = 1'b1;
            end
        endcase
        if (op[1:0] != 2'b11) begin
            bad = 1'b1;
        end
        if (bad) begin
            word = 32'h0;
        end
        return {bad, word};
    endfunction

    // Saturating increment for the handshake counters.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

    logic        vld_p1;
    logic        vld_p2;
    logic [2:0]  fmt_p1;
    logic [6:0]  op_p1;
    logic [2:0]  f3_p1;
    logic [6:0]  f7_p1;
    logic [4:0]  rd_p1;
    logic [4:0]  rs1_p1;
    logic [4:0]  rs2_p1;
    logic [31:0] imm_p1;
    logic [31:0] instr_p2;
    logic        err_p2;
    logic [15:0] cnt_ok_p2;
    logic [15:0] cnt_err_p2;
    logic [32:0] enc_p1;
    logic        s1_adv;
    logic        accept;
    logic        out_hs;

    assign s1_adv     = !vld_p2 || out_ready_i;
    assign in_ready_o = !flush_i && (!vld_p1 || s1_adv);
    assign accept     = in_valid_i && in_ready_o;
    assign out_hs     = vld_p2 && out_ready_i;
    assign enc_p1     = encode(fmt_p1, op_p1, f3_p1, f7_p1, rd_p1, rs1_p1, rs2_p1, imm_p1);

    assign out_valid_o = vld_p2;
    assign instr_o     = instr_p2;
    assign err_o       = err_p2;
    assign cnt_ok_o    = cnt_ok_p2;
    assign cnt_err_o   = cnt_err_p2;

    // Valid bits of both stages: flush empties the pipe, otherwise advance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (flush_i) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (in_ready_o) begin
                vld_p1 <= in_valid_i;
            end
            if (s1_adv) begin
                vld_p2 <= vld_p1;
            end
        end
    end

    // ---- stage 1: capture accepted fields ----
    always_ff @(posedge clk_i) begin
        if (accept) begin
            fmt_p1 <= format_i;
            op_p1  <= op_i;
            f3_p1  <= funct_3_i;
            f7_p1  <= funct_7_i;
            rd_p1  <= rd_i;
            rs1_p1 <= rs1_i;
            rs2_p1 <= rs2_i;
            imm_p1 <= imm_i;
        end
    end

    // ---- stage 2: encoded word, held while the consumer stalls ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_p2 <= 32'h0;
            err_p2   <= 1'b0;
        end else if (s1_adv && vld_p1 && !flush_i) begin
            instr_p2 <= enc_p1[31:0];
            err_p2   <= enc_p1[32];
        end
    end

    // Count completed output handshakes; a flush does not cancel one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_ok_p2  <= 16'h0;
            cnt_err_p2 <= 16'h0;
        end else if (out_hs) begin
            if (err_p2) begin
                cnt_err_p2 <= sat_inc(cnt_err_p2);
            end else begin
                cnt_ok_p2 <= sat_inc(cnt_ok_p2);
            end
        end
    end

endmodule

// File: tb/tb_riscv_encoder.sv
// Scoreboard bench for riscv_encoder: directed vectors with hand-packed words.
module tb_riscv_encoder;

    logic        clk;
    logic        rst_ni;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        err;
    logic [15:0] cnt_ok;
    logic [15:0] cnt_err;

    riscv_encoder dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .format_i   (fmt),
        .op_i       (op),
        .funct_3_i  (f3),
        .funct_7_i  (f7),
        .rd_i       (rd),
        .rs1_i      (rs1),
        .rs2_i      (rs2),
        .imm_i      (imm),
        .flush_i    (flush),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .instr_o    (instr),
        .err_o      (err),
        .cnt_ok_o   (cnt_ok),
        .cnt_err_o  (cnt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        err;
        logic [31:0] word;
    } vec_t;

    vec_t        vecs[15];
    logic [32:0] sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          exp_ok   = 0;
    int          exp_err  = 0;
    logic        prev_stall = 1'b0;
    logic [32:0] prev_word  = 33'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] f, input logic [6:0] o, input logic [2:0] a3,
                                input logic [6:0] a7, input logic [4:0] d, input logic [4:0] s1,
                                input logic [4:0] s2, input logic [31:0] im,
                                input logic e, input logic [31:0] w);
        vec_t v;
        v.fmt = f; v.op = o; v.f3 = a3; v.f7 = a7; v.rd = d;
        v.rs1 = s1; v.rs2 = s2; v.imm = im; v.err = e; v.word = w;
        return v;
    endfunction

    task automatic drive(input int idx);
        fmt = vecs[idx].fmt; op = vecs[idx].op; f3 = vecs[idx].f3; f7 = vecs[idx].f7;
        rd = vecs[idx].rd; rs1 = vecs[idx].rs1; rs2 = vecs[idx].rs2; imm = vecs[idx].imm;
    endtask

    // Present one vector and hold it until the DUT takes it. Leaves in_valid high.
    task automatic send(input int idx);
        bit acc;
        acc = 1'b0;
        drive(idx);
        in_valid = 1'b1;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (acc) sb_q.push_back({vecs[idx].err, vecs[idx].word});
        end
        #1;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: vector %0d never accepted", idx);
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 50 && sb_q.size() > 0; c++) @(posedge clk);
        #1;
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    // Monitor: pops the expected word on every output handshake, and checks
    // that a stalled word does not change.
    always @(negedge clk) begin
        if (!rst_ni) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && out_valid) chk("stall_hold", {31'h0, err, instr}, {31'h0, prev_word});
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_word", {31'h0, err, instr}, 64'h1_0000_0000_0000);
                end else begin
                    logic [32:0] e;
                    e = sb_q.pop_front();
                    chk("word", {31'h0, err, instr}, {31'h0, e});
                    if (e[32]) exp_err++; else exp_ok++;
                end
            end
            prev_stall <= out_valid && !out_ready;
            prev_word  <= {err, instr};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int nxt;
        bit a;
        vecs[0]  = mk(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'h0000_0005, 1'b0, 32'h0051_0093);
        vecs[1]  = mk(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'h0000_0800, 1'b0, 32'h0020_80E3);
        vecs[2]  = mk(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'h0000_0801, 1'b1, 32'h0);
        vecs[3]  = mk(3'd6, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0,         1'b1, 32'h0);
        vecs[4]  = mk(3'd0, 7'h13, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0,         1'b1, 32'h0);
        vecs[5]  = mk(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0,         1'b0, 32'h0020_81B3);
        vecs[6]  = mk(3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'h0,         1'b0, 32'h4020_81B3);
        vecs[7]  = mk(3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'h0000_0008, 1'b0, 32'h0020_A423);
        vecs[8]  = mk(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0, 32'h1234_52B7);
        vecs[9]  = mk(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 1'b0, 32'h0010_00EF);
        vecs[10] = mk(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_0801, 1'b1, 32'h0);
        vecs[11] = mk(3'd1, 7'h12, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'h0000_0005, 1'b1, 32'h0);
        vecs[12] = mk(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFF_F005, 1'b0, 32'h0051_0093);
        vecs[13] = mk(3'd7, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0,         1'b1, 32'h0);
        vecs[14] = mk(3'd1, 7'h03, 3'd2, 7'h00, 5'd1, 5'd2, 5'd0, 32'h0000_0004, 1'b0, 32'h0041_2083);

        rst_ni = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_instr",     64'(instr),     64'd0);
        chk("rst_err",       64'(err),       64'd0);
        chk("rst_cnt_ok",    64'(cnt_ok),    64'd0);
        chk("rst_cnt_err",   64'(cnt_err),   64'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Single ADDI: latency of two edges after acceptance.
        out_ready = 1'b1;
        send(0);
        in_valid = 1'b0;
        chk("lat_n1_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_n2_valid", 64'(out_valid), 64'd1);
        chk("lat_n2_instr", 64'(instr), 64'h0051_0093);
        drain();
        chk("addi_cnt_ok",  64'(cnt_ok),  64'd1);
        chk("addi_cnt_err", 64'(cnt_err), 64'd0);

        // Back-to-back stream of the remaining vectors.
        for (int i = 1; i < 15; i++) send(i);
        in_valid = 1'b0;
        drain();
        chk("stream_cnt_ok",  64'(cnt_ok),  64'd9);
        chk("stream_cnt_err", 64'(cnt_err), 64'd6);

        // Backpressure: consumer stalled for three cycles.
        out_ready = 1'b0;
        nxt = 0;
        drive(5);
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            a = in_ready;
            @(posedge clk);
            if (a) begin
                sb_q.push_back({vecs[5 + nxt].err, vecs[5 + nxt].word});
                nxt++;
            end
            #1;
            if (nxt < 4) drive(5 + nxt);
        end
        chk("bp_accepts", 64'(nxt), 64'd2);
        #1;
        chk("bp_ready_low", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        while (nxt < 4) begin
            send(5 + nxt);
            nxt++;
        end
        in_valid = 1'b0;
        drain();
        chk("bp_cnt_ok", 64'(cnt_ok), 64'd13);

        // Flush with both stages full; the input offered in that cycle is dropped.
        out_ready = 1'b0;
        send(7);
        send(8);
        drive(9);
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb_q.delete();
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_cnt_ok",    64'(cnt_ok),    64'(exp_ok));
        chk("flush_cnt_err",   64'(cnt_err),   64'(exp_err));
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("flush_idle_valid", 64'(out_valid), 64'd0);

        // A handshake in the flush cycle still counts.
        send(0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_hs_cnt_ok", 64'(cnt_ok), 64'd14);
        chk("flush_hs_empty",  64'(sb_q.size()), 64'd0);

        // Asynchronous reset with words in flight.
        out_ready = 1'b0;
        send(14);
        send(0);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_instr",     64'(instr),     64'd0);
        chk("arst_err",       64'(err),       64'd0);
        chk("arst_cnt_ok",    64'(cnt_ok),    64'd0);
        chk("arst_cnt_err",   64'(cnt_err),   64'd0);
        sb_q.delete();
        exp_ok  = 0;
        exp_err = 0;
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("arst_idle_valid", 64'(out_valid), 64'd0);
        send(0);
        in_valid = 1'b0;
        drain();
        chk("arst_cnt_ok_after", 64'(cnt_ok), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
